// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding, frame width default and nRF24L01 command opcodes.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SETUP     = 3'd1;
    localparam logic [2:0] SHIFT     = 3'd2;
    localparam logic [2:0] DONE      = 3'd3;
    localparam logic [2:0] WAIT_NEXT = 3'd4;
    localparam logic [2:0] HOLD      = 3'd5;
    localparam logic [2:0] GAP       = 3'd6;

    localparam logic [7:0] NRF_R_REGISTER   = 8'h00;
    localparam logic [7:0] NRF_W_REGISTER   = 8'h20;
    localparam logic [7:0] NRF_R_RX_PAYLOAD = 8'h61;
    localparam logic [7:0] NRF_W_TX_PAYLOAD = 8'hA0;
    localparam logic [7:0] NRF_FLUSH_TX     = 8'hE1;
    localparam logic [7:0] NRF_FLUSH_RX     = 8'hE2;
    localparam logic [7:0] NRF_NOP          = 8'hFF;

endpackage

// File: rtl/spi_master_byte.sv
// spi_master_byte: mode-0, MSB-first SPI byte master advanced by a divider tick enable.
module spi_master_byte
    import spi_pkg::*;
#(
    parameter int DATA_W        = SPI_DATA_W,
    parameter int CSN_GAP_TICKS = 2
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic              tick,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              csn
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    logic [2:0]        state;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic              last;
    logic [3:0]        gap;
    logic              accept;

    assign accept = tx_valid && tx_ready;

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            csn      <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            gap      <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            last     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    tx_ready <= !accept;
                    if (accept) begin
                        tx_sh <= tx_data;
                        last  <= tx_last;
                        mosi  <= tx_data[DATA_W-1];
                        csn   <= 1'b0;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: if (tick) begin
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: if (tick) begin
                    sclk <= !sclk;
                    if (!sclk)
                        rx_sh <= {rx_sh[DATA_W-2:0], miso};
                    else if (bit_cnt == LAST_BIT)
                        state <= DONE;
                    else begin
                        bit_cnt <= bit_cnt + BW'(1);
                        tx_sh   <= tx_sh << 1;
                        mosi    <= tx_sh[DATA_W-2];
                    end
                end
                DONE: begin
                    rx_valid <= 1'b1;
                    rx_data  <= rx_sh;
                    tx_ready <= !last;
                    state    <= last ? HOLD : WAIT_NEXT;
                end
                WAIT_NEXT: if (accept) begin
                    tx_sh    <= tx_data;
                    last     <= tx_last;
                    mosi     <= tx_data[DATA_W-1];
                    tx_ready <= 1'b0;
                    bit_cnt  <= '0;
                    state    <= SHIFT;
                end
                HOLD: if (tick) begin
                    csn   <= 1'b1;
                    gap   <= 4'(CSN_GAP_TICKS);
                    state <= GAP;
                end
                GAP: if (tick) begin
                    // the tick that drains the counter also reopens the interface
                    gap <= (gap <= 4'd1) ? 4'd0 : gap - 4'd1;
                    if (gap <= 4'd1) begin
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_byte.sv
// tb_spi_master_byte: directed vector table plus hand-written multi-cycle sequences.
module tb_spi_master_byte;
    import spi_pkg::*;

    logic       clk_50, rst, tick, tx_valid, tx_ready, tx_last, rx_valid, busy;
    logic       sclk, mosi, miso, csn;
    logic [7:0] tx_data, rx_data;
    logic       tick_en;
    logic [1:0] miso_mode;

    int checks = 0;
    int failures = 0;
    int rises = 0;
    int csn_rises = 0;
    int gap_ticks = 0;
    int viol = 0;
    logic [31:0] mosi_cap = '0;
    logic [7:0]  rx_q[$];

    spi_master_byte #(.DATA_W(8), .CSN_GAP_TICKS(2)) dut (
        .clk_50(clk_50), .rst(rst), .tick(tick), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_last(tx_last), .rx_valid(rx_valid), .rx_data(rx_data),
        .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .csn(csn)
    );

    assign miso = (miso_mode == 2'd2) ? mosi : miso_mode[0];

    initial begin
        clk_50 = 1'b0;
        forever #10 clk_50 = !clk_50;
    end

    initial begin
        int cnt;
        cnt = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk_50);
            #1;
            cnt = (cnt == 4) ? 0 : cnt + 1;
            tick = tick_en && cnt == 0;
        end
    end

    initial begin
        logic prev_sclk, prev_csn;
        prev_sclk = 1'b0;
        prev_csn = 1'b1;
        forever begin
            @(negedge clk_50);
            if (!prev_sclk && sclk && !csn) begin
                rises++;
                mosi_cap = {mosi_cap[30:0], mosi};
            end
            if (rx_valid) rx_q.push_back(rx_data);
            if (!prev_csn && csn) csn_rises++;
            if (sclk && csn) viol++;
            if (csn && busy && tx_ready) viol++;
            if (csn && busy && tick) gap_ticks++;
            prev_sclk = sclk;
            prev_csn = csn;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        tx_valid = 1'b1;
        tx_data = d;
        tx_last = l;
        for (int i = 0; i < 3000; i++) begin
            if (tx_ready) begin
                @(posedge clk_50);
                #1;
                tx_valid = 1'b0;
                return;
            end
            @(posedge clk_50);
            #1;
        end
        tx_valid = 1'b0;
        timeout("send_accept");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk_50);
            #1;
            if (!busy) return;
        end
        timeout("wait_idle");
    endtask

    task automatic wait_rises(input int n);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_50);
            if (rises >= n) return;
        end
        timeout("wait_rises");
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int r0, q0, c0, g0, chg;
        logic s_sclk, s_mosi, s_csn;
        vecs[0] = '{8'hA5, 2'd2, 8'hA5};
        vecs[1] = '{8'h80, 2'd0, 8'h00};
        vecs[2] = '{8'h3C, 2'd1, 8'hFF};
        vecs[3] = '{8'h5A, 2'd2, 8'h5A};
        vecs[4] = '{8'h01, 2'd0, 8'h00};

        rst = 1'b1;
        tx_valid = 1'b0;
        tx_data = '0;
        tx_last = 1'b0;
        tick_en = 1'b1;
        miso_mode = 2'd0;
        #35;
        chk("rst_csn", 32'(csn), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk_50);
        rst = 1'b0;
        @(posedge clk_50);
        #1;
        chk("ready_after_reset", 32'(tx_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            miso_mode = vecs[i].mode;
            r0 = rises;
            q0 = rx_q.size();
            c0 = csn_rises;
            send(vecs[i].data, 1'b1);
            wait_idle();
            chk($sformatf("v%0d_rises", i), 32'(rises - r0), 32'd8);
            chk($sformatf("v%0d_mosi", i), 32'(mosi_cap[7:0]), 32'(vecs[i].data));
            chk($sformatf("v%0d_rx_count", i), 32'(rx_q.size() - q0), 32'd1);
            chk($sformatf("v%0d_rx_data", i), 32'(rx_q[q0]), 32'(vecs[i].exp_rx));
            chk($sformatf("v%0d_csn_rises", i), 32'(csn_rises - c0), 32'd1);
        end

        // three-byte W_REGISTER with CSN held low throughout
        miso_mode = 2'd1;
        r0 = rises;
        q0 = rx_q.size();
        c0 = csn_rises;
        send(NRF_W_REGISTER, 1'b0);
        send(8'h03, 1'b0);
        send(8'h01, 1'b1);
        wait_idle();
        chk("multi_rises", 32'(rises - r0), 32'd24);
        chk("multi_mosi", {8'h0, mosi_cap[23:0]}, 32'h0020_0301);
        chk("multi_rx_count", 32'(rx_q.size() - q0), 32'd3);
        for (int k = 0; k < 3; k++) chk($sformatf("multi_rx%0d", k), 32'(rx_q[q0 + k]), 32'hFF);
        chk("multi_csn_rises", 32'(csn_rises - c0), 32'd1);

        // back-to-back: valid held high through HOLD/GAP must be ignored
        miso_mode = 2'd2;
        q0 = rx_q.size();
        c0 = csn_rises;
        g0 = gap_ticks;
        send(8'hC6, 1'b1);
        send(8'h39, 1'b1);
        wait_idle();
        chk("b2b_rx_count", 32'(rx_q.size() - q0), 32'd2);
        chk("b2b_rx0", 32'(rx_q[q0]), 32'hC6);
        chk("b2b_rx1", 32'(rx_q[q0 + 1]), 32'h39);
        chk("b2b_csn_rises", 32'(csn_rises - c0), 32'd2);
        chk("b2b_gap_min", 32'(gap_ticks - g0 >= 4), 32'd1);

        // tick stall mid-byte
        r0 = rises;
        q0 = rx_q.size();
        send(8'hC3, 1'b1);
        wait_rises(r0 + 3);
        tick_en = 1'b0;
        repeat (2) @(negedge clk_50);
        s_sclk = sclk;
        s_mosi = mosi;
        s_csn = csn;
        chg = 0;
        repeat (100) begin
            @(negedge clk_50);
            if (sclk !== s_sclk || mosi !== s_mosi || csn !== s_csn) chg++;
        end
        chk("stall_frozen", 32'(chg), 32'd0);
        chk("stall_csn_low", 32'(s_csn), 32'd0);
        tick_en = 1'b1;
        wait_idle();
        chk("stall_rises", 32'(rises - r0), 32'd8);
        chk("stall_rx_count", 32'(rx_q.size() - q0), 32'd1);
        chk("stall_rx_data", 32'(rx_q[q0]), 32'hC3);

        // asynchronous reset after the fourth rise
        r0 = rises;
        q0 = rx_q.size();
        send(8'hFF, 1'b1);
        wait_rises(r0 + 4);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_csn", 32'(csn), 32'd1);
        chk("arst_sclk", 32'(sclk), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk_50);
        chk("arst_no_rx", 32'(rx_q.size() - q0), 32'd0);
        chk("arst_tx_ready", 32'(tx_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk_50);
        #1;
        chk("arst_ready_after", 32'(tx_ready), 32'd1);
        repeat (20) @(negedge clk_50);
        chk("arst_still_no_rx", 32'(rx_q.size() - q0), 32'd0);

        chk("protocol_violations", 32'(viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master_byte.md
Name: spi_master_byte

Overview:
- Byte-level SPI master for the nRF24L01 link, mode 0 (CPOL=0, CPHA=0), MSB first.
- Sits directly downstream of the SPI clock-divider stage and consumes its one-cycle `tick` strobe (one tick per SCLK half-period) as a clock enable. The divided clock is never used as a clock.
- Generates SCLK, MOSI and CSN, and samples MISO.
- Exposes a valid/ready byte interface to the nRF24 command controller; multi-byte commands hold CSN low until the byte flagged `tx_last`.

Parameters:
- DATA_W, 8, bits per SPI frame.
- CSN_GAP_TICKS, 2, minimum number of ticks CSN stays high between transactions (range 1..15).

Ports:
- clk_50  input  1  system clock, 50 MHz; sole clock.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  one-cycle strobe from the divider, one per SCLK half-period.
- tx_valid  input  1  tx_data/tx_last are valid.
- tx_ready  output  1  block accepts a byte this cycle.
- tx_data  input  DATA_W  byte to transmit.
- tx_last  input  1  this byte ends the transaction (CSN released after it).
- rx_valid  output  1  one-cycle pulse; rx_data holds the byte received.
- rx_data  output  DATA_W  byte shifted in from MISO.
- busy  output  1  high whenever CSN is low or the CSN gap is running.
- sclk  output  1  SPI clock, idles low.
- mosi  output  1  SPI data out.
- miso  input  1  SPI data in; the bench/board handles synchronisation.
- csn  output  1  chip select, active low.

Behaviour:
- All outputs are registered. While rst=1, asynchronously: csn=1, sclk=0, mosi=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, state=IDLE, gap counter=0.
- tx_ready=1 from the first clk_50 edge after reset release.
- Accept occurs when tx_valid && tx_ready on a clk_50 edge. tx_ready is high only in IDLE (gap expired) and WAIT_NEXT.
- States:
  - IDLE: csn=1, sclk=0. On accept: latch tx_data and tx_last, mosi<=tx_data[7], csn<=0, tx_ready<=0, go SETUP. A tick in the accept cycle is ignored.
  - SETUP: on the next tick go SHIFT with bit_cnt=0. This gives at least one half-period of CSN setup before the first SCLK rise.
  - SHIFT, each tick toggles sclk:
    - Rising edge (0->1): shift miso into the LSB of the rx shift register.
    - Falling edge (1->0) with bit_cnt<7: mosi<=next bit, bit_cnt++.
    - Falling edge with bit_cnt==7: go DONE.
    - One byte = exactly 16 ticks after SETUP = 8 rising edges.
  - DONE (one clk_50): rx_valid=1 and rx_data=shift register.
    - If last: go HOLD.
    - Else: go WAIT_NEXT with tx_ready=1.
  - WAIT_NEXT: csn stays 0, sclk stays 0. On accept: mosi<=tx_data[7], latch tx_last, go SHIFT directly. There is no extra setup tick; at least one tick separates bytes.
  - HOLD: on the next tick csn<=1, load the gap counter with CSN_GAP_TICKS, go GAP.
  - GAP: decrement on each tick; at 0 go IDLE and assert tx_ready.
- tx_valid while tx_ready=0 is ignored and need not be held stable.
- rx_valid has no backpressure; the consumer must take it in its pulse cycle.
- If tick never arrives, the FSM stalls in its current state indefinitely, with outputs stable.
- Reset mid-transaction: CSN deasserts in the same cycle rst rises. The partial byte is discarded and rx_valid is not pulsed.
- sclk is never high outside SHIFT; csn never toggles while sclk=1.

Decomposition:
- Package spi_pkg holds the FSM state encoding (IDLE, SETUP, SHIFT, DONE, WAIT_NEXT, HOLD, GAP), the DATA_W default and the nRF24 command opcodes used by benches.
- No sub-module: the shift register and bit counter stay inline. Sub-modules add nothing at this size.

Test Plan:
- Single byte: tx_data=0xA5, tx_last=1, miso looped from mosi, tick every 5 clk_50 -> 8 sclk rises while csn=0, mosi sequence 1,0,1,0,0,1,0,1, one rx_valid with rx_data=0xA5, csn high after the next tick.
- Three-byte W_REGISTER: 0x20, 0x03, 0x01 with last on the third byte, miso held 1 -> csn low continuously across 24 rises, three rx_valid pulses each 0xFF, csn rises exactly once.
- Bit order: tx 0x80, miso=0 -> mosi high only before the first rise, rx_data=0x00.
- Back-to-back transactions with CSN_GAP_TICKS=2 -> csn high for at least 2 ticks, tx_ready=0 until the gap expires.
- Tick stall: stop tick mid-byte for 100 clk_50 -> sclk, mosi and csn frozen, the byte completes correctly after tick resumes.
- Reset after the 4th rise: rst=1 asynchronously -> csn=1, sclk=0 immediately, no rx_valid; tx_ready=1 one cycle after release.
